// File: rtl/t_framer.sv
// Transmit framer: 12-bit payload words in, back-to-back 16-bit {HEADER, payload} frames out MSB first.
// Optional TFRAMER_ERRINJ_EN adds an err_inj input that inverts the header of the frame loaded that edge.
module t_framer #(
  parameter logic [3:0] HEADER      = 4'd6,
  parameter int         SYNC_FRAMES = 3
) (
  input  logic        clk,
  input  logic        rst,
`ifdef TFRAMER_ERRINJ_EN
  input  logic        err_inj,
`endif
  input  logic [11:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        data_out,
  output logic        frame_start,
  output logic        synced
);

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int SW = (SYNC_FRAMES > 1) ? $clog2(SYNC_FRAMES) : 1;
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_FRAMES - 1);

  state_t        state, state_nxt;
  logic [15:0]   sreg, sreg_nxt;
  logic [3:0]    bit_cnt;
  logic [SW-1:0] sync_cnt, sync_cnt_nxt;
  logic [11:0]   buf_data, buf_nxt;
  logic          buf_full, buf_full_nxt;
  logic          load;
  logic          xfer;
  logic [3:0]    hdr;

  assign load = (bit_cnt == 4'd15);

`ifdef TFRAMER_ERRINJ_EN
  assign hdr = err_inj ? ~HEADER : HEADER;
`else
  assign hdr = HEADER;
`endif

  // Handshake: a word transfers on any rising edge where data_valid and data_ready are both high.
  // data_ready depends only on internal state, never on data_valid.
  assign data_ready  = (state == RUN) && (!buf_full || load);
  assign xfer        = data_valid && data_ready;
  assign data_out    = sreg[15];
  assign frame_start = (bit_cnt == 4'd0);
  assign synced      = (state == RUN);

  always_comb begin
    state_nxt    = state;
    sreg_nxt     = {sreg[14:0], 1'b0};
    sync_cnt_nxt = sync_cnt;
    buf_nxt      = buf_data;
    buf_full_nxt = buf_full;
    if (load) begin
      sreg_nxt = {hdr, 12'h000};
      if (state == SYNC) begin
        sync_cnt_nxt = sync_cnt + 1'b1;
        if (sync_cnt == SYNC_LAST) state_nxt = RUN;
      end else if (buf_full) begin
        // Older buffered word goes out first; a word arriving now refills the buffer.
        sreg_nxt = {hdr, buf_data};
        if (xfer) buf_nxt = data_in;
        else      buf_full_nxt = 1'b0;
      end else if (xfer) begin
        sreg_nxt = {hdr, data_in};
      end
    end else if (xfer) begin
      buf_nxt      = data_in;
      buf_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SYNC;
      sreg     <= {HEADER, 12'h000};
      bit_cnt  <= 4'd0;
      sync_cnt <= '0;
      buf_data <= 12'h000;
      buf_full <= 1'b0;
    end else begin
      state    <= state_nxt;
      sreg     <= sreg_nxt;
      bit_cnt  <= bit_cnt + 4'd1;
      sync_cnt <= sync_cnt_nxt;
      buf_data <= buf_nxt;
      buf_full <= buf_full_nxt;
    end
  end

endmodule

// File: tb/tb_t_framer.sv
// Bench for t_framer: a frame-level reference model queues expected frames; a negedge monitor
// reassembles the serial stream and compares frames and per-cycle status outputs.
module tb_t_framer;
  localparam logic [3:0] HEADER      = 4'd6;
  localparam int         SYNC_FRAMES = 3;

  logic        clk;
  logic        rst;
  logic        err_inj;
  logic [11:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic        data_out;
  logic        frame_start;
  logic        synced;

  int n_checks;
  int n_errors;

  t_framer #(.HEADER(HEADER), .SYNC_FRAMES(SYNC_FRAMES)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef TFRAMER_ERRINJ_EN
    .err_inj    (err_inj),
`endif
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_out   (data_out),
    .frame_start(frame_start),
    .synced     (synced)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words accepted form a FIFO; each frame boundary after the preamble
  // takes the oldest pending word (or idles). Frame period is a fixed 16 cycles.
  logic [15:0] exp_q[$];
  logic [11:0] pend_q[$];
  int          m_pos;
  int          m_loaded;
  bit          m_run;
  bit          m_last_acc;

  function automatic logic model_ready();
    return m_run && (pend_q.size() == 0 || m_pos == 15);
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [11:0] pay;
    logic [3:0]  hdr;
    if (rst) begin
      m_pos = 0; m_run = 0; m_loaded = 0; m_last_acc = 0;
      pend_q.delete();
      exp_q.delete();
      exp_q.push_back({HEADER, 12'h000});
    end else begin
      m_last_acc = data_valid && model_ready();
      if (m_last_acc) pend_q.push_back(data_in);
      if (m_pos == 15) begin
        hdr = HEADER;
`ifdef TFRAMER_ERRINJ_EN
        if (err_inj) hdr = ~HEADER;
`endif
        pay = 12'h000;
        if (m_run && pend_q.size() > 0) pay = pend_q.pop_front();
        if (!m_run) begin
          m_loaded++;
          if (m_loaded == SYNC_FRAMES) m_run = 1;
        end
        exp_q.push_back({hdr, pay});
      end
      m_pos = (m_pos + 1) % 16;
    end
  end

  // Monitor
  logic [15:0] mon_bits;
  int          mon_n;
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst) begin
      mon_bits = '0; mon_n = 0;
      chk("rst_data_out", data_out, HEADER[3]);
      chk("rst_frame_start", frame_start, 1'b1);
      chk("rst_synced", synced, 1'b0);
      chk("rst_data_ready", data_ready, 1'b0);
    end else begin
      chk("frame_start", frame_start, m_pos == 0);
      chk("synced", synced, m_run);
      chk("data_ready", data_ready, model_ready());
      mon_bits = {mon_bits[14:0], data_out};
      mon_n++;
      if (mon_n == 16) begin
        mon_n = 0;
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL frame_unexpected: got %h expected none at %0t", mon_bits, $time);
        end else begin
          e = exp_q.pop_front();
          chk("frame", mon_bits, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic send_word(input logic [11:0] d);
    int k;
    data_valid = 1'b1;
    data_in    = d;
    for (k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (m_last_acc) break;
    end
    if (k == 100) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: got no transfer expected transfer of %h", d);
    end
    data_valid = 1'b0;
  endtask

  task automatic wait_for(input int pos, input int pend, input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (m_run && m_pos == pos && pend_q.size() == pend) break;
    end
    if (k == 200) begin
      n_checks++; n_errors++;
      $display("FAIL %s_timeout: got no match expected pos %0d pend %0d", name, pos, pend);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b0; err_inj = 1'b0; data_valid = 1'b0; data_in = 12'h000;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Preamble and idle stream
    idle_cycles(70);

    // Single transfer at a non-load edge
    wait_for(4, 0, "single");
    send_word(12'hABC);
    idle_cycles(40);

    // Held valid, buffer fills and drains one per frame
    send_word(12'h001);
    send_word(12'h002);
    send_word(12'h003);
    idle_cycles(50);

    // Bypass: transfer exactly on the load edge with empty buffer
    wait_for(15, 0, "bypass");
    send_word(12'h5A5);
    chk("bypass_ready", data_ready, 1'b1);
    idle_cycles(40);

    // Reset at bit 7 of a data frame with the buffer full
    send_word(12'h111);
    send_word(12'h222);
    wait_for(7, 1, "rst_mid");
    rst = 1'b1;
    #1;
    chk("async_data_out", data_out, HEADER[3]);
    chk("async_frame_start", frame_start, 1'b1);
    chk("async_synced", synced, 1'b0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    idle_cycles(47);
    chk("synced_before_48", synced, 1'b0);
    idle_cycles(1);
    chk("synced_at_48", synced, 1'b1);
    idle_cycles(20);

    // Randomized traffic, one reset midway
    for (int c = 0; c < 1400; c++) begin
      if (c == 700) begin
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
      end
      if (!data_valid || m_last_acc) begin
        data_valid = ($urandom_range(0, 3) != 0);
        data_in    = 12'($urandom);
      end
`ifdef TFRAMER_ERRINJ_EN
      err_inj = ($urandom_range(0, 15) == 0);
`endif
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
    err_inj    = 1'b0;
    idle_cycles(64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
